// File: rtl/spy_host.sv
// Host-side initiator for the serial spy byte protocol: issues command bytes to a
// UART TX stream and, for reads, rebuilds the 16-bit word from four RX reply bytes.
module spy_host #(
    parameter int unsigned    TW      = 24,
    parameter logic [TW-1:0]  TIMEOUT = TW'(5000000)
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [3:0]  req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [15:0] rsp_data,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic        busy
);

    typedef enum logic [1:0] {S_IDLE, S_TX, S_RX, S_DONE} state_t;

    state_t        r_state, w_next;
    logic          r_write;
    logic [3:0]    r_addr;
    logic [15:0]   r_wdata;
    logic [2:0]    r_idx;
    logic [TW-1:0] r_cnt;
    logic [15:0]   r_word;
    logic [15:0]   r_rsp_data;
    logic          r_err;

    logic          w_accept, w_tx_hs, w_last, w_rx_ok, w_rx_bad, w_tmo;
    logic [3:0]    w_exp_op;
    logic [7:0]    w_byte;

    assign w_accept = req_valid && req_ready;
    assign w_tx_hs  = tx_valid && tx_ready;
    assign w_last   = r_write ? (r_idx == 3'd4) : 1'b1;
    assign w_exp_op = 4'd3 + {2'b00, r_idx[1:0]};
    assign w_rx_ok  = rx_valid && (rx_byte[7:4] == w_exp_op);
    assign w_rx_bad = rx_valid && (rx_byte[7:4] != w_exp_op);
    assign w_tmo    = !rx_valid && (r_cnt == TIMEOUT - TW'(1));
    assign rsp_data = r_rsp_data;

    always_comb begin
        case (r_idx)
            3'd0:    w_byte = r_write ? {4'd3, r_wdata[15:12]} : {4'd8, r_addr};
            3'd1:    w_byte = {4'd4, r_wdata[11:8]};
            3'd2:    w_byte = {4'd5, r_wdata[7:4]};
            3'd3:    w_byte = {4'd6, r_wdata[3:0]};
            default: w_byte = {4'd9, r_addr};
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // req_ready is gated by reset_n so every output reads 0 while reset is held
    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        tx_valid  = 1'b0;
        tx_byte   = '0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        busy      = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                req_ready = reset_n;
                if (w_accept) w_next = S_TX;
            end
            S_TX: begin
                tx_valid = 1'b1;
                tx_byte  = w_byte;
                if (w_tx_hs && w_last) w_next = r_write ? S_DONE : S_RX;
            end
            S_RX: begin
                if ((w_rx_ok && r_idx == 3'd3) || w_rx_bad || w_tmo) w_next = S_DONE;
            end
            S_DONE: begin
                rsp_valid = 1'b1;
                rsp_err   = r_err;
                w_next    = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_write    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_word     <= '0;
            r_rsp_data <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_write <= req_write;
                    r_addr  <= req_addr;
                    r_wdata <= req_wdata;
                    r_idx   <= '0;
                end
                S_TX: if (w_tx_hs) begin
                    if (w_last) begin
                        r_idx  <= '0;
                        r_cnt  <= '0;
                        r_word <= '0;
                        if (r_write) r_err <= 1'b0;
                    end else begin
                        r_idx <= r_idx + 3'd1;
                    end
                end
                S_RX: begin
                    if (w_rx_ok) begin
                        case (r_idx[1:0])
                            2'd0: r_word[15:12] <= rx_byte[3:0];
                            2'd1: r_word[11:8]  <= rx_byte[3:0];
                            2'd2: r_word[7:4]   <= rx_byte[3:0];
                            default: r_word[3:0] <= rx_byte[3:0];
                        endcase
                        r_idx <= r_idx + 3'd1;
                        r_cnt <= '0;
                        if (r_idx == 3'd3) begin
                            r_rsp_data <= {r_word[15:4], rx_byte[3:0]};
                            r_err      <= 1'b0;
                        end
                    end else if (w_rx_bad || w_tmo) begin
                        r_rsp_data <= '0;
                        r_err      <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
